// File: rtl/cex_controller_pkg.sv
// Shared CPU definitions for the conditional-execution controller.
//   - status flag bit positions within the PSW nibble
//   - cond_code_e: the 16 condition codes used by branches and CEX
//   - cex_state_e: CEX block tracking states
package cpu_pkg;

    localparam int unsigned C_BIT = 0;
    localparam int unsigned Z_BIT = 1;
    localparam int unsigned N_BIT = 2;
    localparam int unsigned V_BIT = 3;

    typedef enum logic [3:0] {
        EQ = 4'd0,  NE = 4'd1,  HS = 4'd2,  LO = 4'd3,
        MI = 4'd4,  PL = 4'd5,  VS = 4'd6,  VC = 4'd7,
        HI = 4'd8,  LS = 4'd9,  GE = 4'd10, LT = 4'd11,
        GT = 4'd12, LE = 4'd13, TR = 4'd14, FL = 4'd15
    } cond_code_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PHASE_T = 2'd1,
        PHASE_F = 2'd2
    } cex_state_e;

endpackage

// File: rtl/cex_controller_if.sv
// Bus between the control unit and the CEX controller.
//   master: control-unit side, drives status/conditions/CEX operands/retire/flush
//   slave : cex_controller side, returns br_result, exec_en, cex_active
interface cex_controller_if #(
    parameter int unsigned CNT_W = 3
);
    logic [3:0]       status;
    logic [3:0]       br_cond;
    logic             br_result;
    logic             cex_load;
    logic [3:0]       cex_cond;
    logic [CNT_W-1:0] cex_tcnt;
    logic [CNT_W-1:0] cex_fcnt;
    logic             instr_retire;
    logic             flush;
    logic             exec_en;
    logic             cex_active;

    modport master (
        output status, br_cond, cex_load, cex_cond, cex_tcnt, cex_fcnt, instr_retire, flush,
        input  br_result, exec_en, cex_active
    );

    modport slave (
        input  status, br_cond, cex_load, cex_cond, cex_tcnt, cex_fcnt, instr_retire, flush,
        output br_result, exec_en, cex_active
    );
endinterface

// File: rtl/cex_controller_cond_eval.sv
// Combinational condition evaluator: 4-bit condition code against PSW flags.
//   status_i : PSW flags {V, N, Z, C}
//   code_i   : condition code (cond_code_e)
//   result_o : 1 when the condition holds
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] status_i,
    input  logic [3:0] code_i,
    output logic       result_o
);
    logic c, z, n, v;

    assign c = status_i[C_BIT];
    assign z = status_i[Z_BIT];
    assign n = status_i[N_BIT];
    assign v = status_i[V_BIT];

    always_comb begin
        result_o = 1'b0;
        case (cond_code_e'(code_i))
            EQ: result_o = z;
            NE: result_o = !z;
            HS: result_o = c;
            LO: result_o = !c;
            MI: result_o = n;
            PL: result_o = !n;
            VS: result_o = v;
            VC: result_o = !v;
            HI: result_o = c && !z;
            LS: result_o = !c || z;
            GE: result_o = (n == v);
            LT: result_o = (n != v);
            GT: result_o = !z && (n == v);
            LE: result_o = z || (n != v);
            TR: result_o = 1'b1;
            FL: result_o = 1'b0;
            default: result_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/cex_controller.sv
// Conditional-execution controller.
// Evaluates branch conditions combinationally and tracks latched CEX blocks
// (a true phase followed by a false phase) to gate commit of retiring instructions.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of cex_controller_if (conditions, CEX operands,
//              retire/flush in; br_result, exec_en, cex_active out)
module cex_controller
    import cpu_pkg::*;
#(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    cex_controller_if.slave  bus
);
    cex_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] fcnt_hold_q, fcnt_hold_d;
    logic             cond_q, cond_d;

    logic cex_eval;
    logic exec_en;
    logic load_acc;

    cond_eval u_br_eval (
        .status_i (bus.status),
        .code_i   (bus.br_cond),
        .result_o (bus.br_result)
    );

    cond_eval u_cex_eval (
        .status_i (bus.status),
        .code_i   (bus.cex_cond),
        .result_o (cex_eval)
    );

    always_comb begin
        exec_en = 1'b1;
        case (state_q)
            PHASE_T: exec_en = cond_q;
            PHASE_F: exec_en = !cond_q;
            default: exec_en = 1'b1;
        endcase
    end

    // A CEX sitting in a suppressed slot is itself not executed.
    assign load_acc       = bus.cex_load && exec_en;
    assign bus.exec_en    = exec_en;
    assign bus.cex_active = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fcnt_hold_d = fcnt_hold_q;
        cond_d      = cond_q;
        if (bus.flush) begin
            state_d     = IDLE;
            cnt_d       = '0;
            fcnt_hold_d = '0;
            cond_d      = 1'b0;
        end else if (load_acc) begin
            // Coincident retire is the CEX itself, so it is not counted.
            cond_d = cex_eval;
            if (bus.cex_tcnt != '0) begin
                state_d     = PHASE_T;
                cnt_d       = bus.cex_tcnt;
                fcnt_hold_d = bus.cex_fcnt;
            end else if (bus.cex_fcnt != '0) begin
                state_d     = PHASE_F;
                cnt_d       = bus.cex_fcnt;
                fcnt_hold_d = '0;
            end else begin
                state_d     = IDLE;
                cnt_d       = '0;
                fcnt_hold_d = '0;
            end
        end else if (bus.instr_retire && (state_q != IDLE)) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                if ((state_q == PHASE_T) && (fcnt_hold_q != '0)) begin
                    state_d     = PHASE_F;
                    cnt_d       = fcnt_hold_q;
                    fcnt_hold_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            fcnt_hold_q <= '0;
            cond_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fcnt_hold_q <= fcnt_hold_d;
            cond_q      <= cond_d;
        end
    end
endmodule

// File: tb/tb_cex_controller.sv
// Directed self-checking bench for cex_controller.
module tb_cex_controller;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    cex_controller_if #(.CNT_W(3)) bus ();

    cex_controller #(.CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference condition table, written from the code list.
    function automatic logic ref_cond(input logic [3:0] code, input logic [3:0] st);
        logic c, z, n, v;
        c = st[0]; z = st[1]; n = st[2]; v = st[3];
        case (code)
            4'd0:  return z;
            4'd1:  return ~z;
            4'd2:  return c;
            4'd3:  return ~c;
            4'd4:  return n;
            4'd5:  return ~n;
            4'd6:  return v;
            4'd7:  return ~v;
            4'd8:  return c & ~z;
            4'd9:  return ~c | z;
            4'd10: return ~(n ^ v);
            4'd11: return n ^ v;
            4'd12: return ~z & ~(n ^ v);
            4'd13: return z | (n ^ v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a CEX load for one cycle (optionally with a coincident retire).
    task automatic cex(input logic [3:0] cond, input logic [2:0] t, input logic [2:0] f,
                       input logic with_retire);
        bus.cex_load     = 1'b1;
        bus.cex_cond     = cond;
        bus.cex_tcnt     = t;
        bus.cex_fcnt     = f;
        bus.instr_retire = with_retire;
        tick();
        bus.cex_load     = 1'b0;
        bus.instr_retire = 1'b0;
    endtask

    // Retire one instruction and check its commit gate.
    task automatic retire(input string tag, input logic exp_en);
        bus.instr_retire = 1'b1;
        #1;
        check_eq(tag, bus.exec_en, exp_en);
        tick();
        bus.instr_retire = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_active"}, bus.cex_active, 1'b0);
        check_eq({tag, "_en"}, bus.exec_en, 1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst              = 1'b1;
        bus.status       = 4'h0;
        bus.br_cond      = 4'h0;
        bus.cex_load     = 1'b0;
        bus.cex_cond     = 4'h0;
        bus.cex_tcnt     = 3'd0;
        bus.cex_fcnt     = 3'd0;
        bus.instr_retire = 1'b0;
        bus.flush        = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_idle("reset");

        // Branch condition sweep.
        for (int code = 0; code < 16; code++) begin
            for (int st = 0; st < 16; st++) begin
                bus.br_cond = 4'(code);
                bus.status  = 4'(st);
                #1;
                check_eq($sformatf("br_c%0d_s%0h", code, st), bus.br_result,
                         ref_cond(4'(code), 4'(st)));
            end
        end
        check_idle("sweep");

        // Z=1, EQ, t=2 f=3: condition true.
        bus.status = 4'b0010;
        cex(4'd0, 3'd2, 3'd3, 1'b0);
        check_eq("eqT_active", bus.cex_active, 1'b1);
        retire("eqT_r1", 1'b1);
        retire("eqT_r2", 1'b1);
        retire("eqT_r3", 1'b0);
        retire("eqT_r4", 1'b0);
        retire("eqT_r5", 1'b0);
        check_idle("eqT_end");

        // Z=0, same load: condition false; flag change mid-block is ignored.
        bus.status = 4'b0000;
        cex(4'd0, 3'd2, 3'd3, 1'b0);
        retire("eqF_r1", 1'b0);
        bus.status = 4'b0010;
        retire("eqF_r2", 1'b0);
        retire("eqF_r3", 1'b1);
        retire("eqF_r4", 1'b1);
        retire("eqF_r5", 1'b1);
        check_idle("eqF_end");

        // Empty true block goes straight to the false phase.
        cex(4'd14, 3'd0, 3'd2, 1'b0);
        check_eq("t0_active", bus.cex_active, 1'b1);
        retire("t0_r1", 1'b0);
        retire("t0_r2", 1'b0);
        check_idle("t0_end");

        cex(4'd14, 3'd0, 3'd0, 1'b0);
        check_idle("t0f0");

        // Flush on the second retire.
        cex(4'd14, 3'd3, 3'd3, 1'b0);
        retire("fl_r1", 1'b1);
        bus.flush = 1'b1;
        retire("fl_r2", 1'b1);
        bus.flush = 1'b0;
        check_idle("fl_end");

        // Reset mid-block.
        cex(4'd15, 3'd2, 3'd2, 1'b0);
        check_eq("rs_pre_en", bus.exec_en, 1'b0);
        check_eq("rs_pre_active", bus.cex_active, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("rs_post");
        bus.br_cond = 4'd8;
        bus.status  = 4'b0001;
        #1;
        check_eq("rs_br", bus.br_result, 1'b1);

        // Load coincident with retire: that retire is the CEX itself.
        cex(4'd14, 3'd2, 3'd0, 1'b1);
        retire("co_r1", 1'b1);
        check_eq("co_mid_active", bus.cex_active, 1'b1);
        retire("co_r2", 1'b1);
        check_idle("co_end");

        // Load in a suppressed slot is ignored but counts as a retire.
        cex(4'd15, 3'd2, 3'd1, 1'b0);
        bus.cex_load = 1'b1;
        bus.cex_cond = 4'd14;
        bus.cex_tcnt = 3'd5;
        bus.cex_fcnt = 3'd5;
        retire("sup_r1", 1'b0);
        bus.cex_load = 1'b0;
        retire("sup_r2", 1'b0);
        retire("sup_r3", 1'b1);
        check_idle("sup_end");

        // Load in an enabled slot restarts the block.
        cex(4'd14, 3'd3, 3'd3, 1'b0);
        retire("rst_r1", 1'b1);
        cex(4'd15, 3'd1, 3'd2, 1'b1);
        retire("rs2_r1", 1'b0);
        retire("rs2_r2", 1'b1);
        retire("rs2_r3", 1'b1);
        check_idle("rs2_end");

        // Maximum counts, no wrap.
        cex(4'd14, 3'd7, 3'd7, 1'b0);
        for (int i = 0; i < 14; i++) begin
            if (i == 13) check_eq("max_last_active", bus.cex_active, 1'b1);
            retire($sformatf("max_r%0d", i + 1), (i < 7) ? 1'b1 : 1'b0);
        end
        check_idle("max_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
